// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the opcodes the upstream write-enable
// decode keys on, and the write-port grant encoding.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [6:0] {
        LOAD = 7'b0000011,
        IMM  = 7'b0010011,
        REG  = 7'b0110011
    } opcode_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LD
    } wb_gnt_e;

endpackage

// File: rtl/wb_ret_fifo.sv
// Load-return FIFO of {rd, data} entries with an occupancy count and per-slot
// rd/valid taps so pending destinations can be looked up combinationally.
module wb_ret_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = cpu_pkg::XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic [REG_ADDR_W-1:0]               push_rd,
    input  logic [XLEN-1:0]                     push_data,
    input  logic                                pop,
    output logic [REG_ADDR_W-1:0]               head_rd,
    output logic [XLEN-1:0]                     head_data,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                full,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd,
    output logic [DEPTH-1:0]                    ent_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]                       wptr;
    logic [PW-1:0]                       rptr;
    logic [CW-1:0]                       cnt;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]    rd_q;
    logic [DEPTH-1:0][XLEN-1:0]          data_q;
    logic [DEPTH-1:0]                    vld_q;

    // Payload registers are not reset; vld_q and cnt alone define occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            vld_q <= '0;
        end else begin
            if (push) begin
                rd_q[wptr]   <= push_rd;
                data_q[wptr] <= push_data;
                vld_q[wptr]  <= 1'b1;
                wptr         <= wptr + PW'(1);
            end
            if (pop) begin
                vld_q[rptr] <= 1'b0;
                rptr        <= rptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_rd   = rd_q[rptr];
    assign head_data = data_q[rptr];
    assign count     = cnt;
    assign full      = (cnt == CW'(DEPTH));
    assign ent_rd    = rd_q;
    assign ent_valid = vld_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order ALU writeback and
// queued load returns; loads win unless the ALU has been starved MAX_STALL cycles.
module wb_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN      = cpu_pkg::XLEN,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [REG_ADDR_W-1:0]       alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    output logic                        alu_stall,
    input  logic                        ld_valid,
    input  logic [REG_ADDR_W-1:0]       ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    output logic                        ld_ready,
    output logic                        rf_we,
    output logic [REG_ADDR_W-1:0]       rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    input  logic [REG_ADDR_W-1:0]       q_rs,
    output logic                        q_pending,
    output logic [$clog2(DEPTH):0]      fifo_count
);

    localparam int unsigned SW = $clog2(MAX_STALL + 1);

    wb_gnt_e                             gnt;
    logic                                alu_req;
    logic                                ld_avail;
    logic                                push;
    logic                                pop;
    logic                                full;
    logic [REG_ADDR_W-1:0]               head_rd;
    logic [XLEN-1:0]                     head_data;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd;
    logic [DEPTH-1:0]                    ent_valid;
    logic [SW-1:0]                       stall_cnt;

    assign alu_req  = alu_valid && (alu_rd != '0);
    // Entries about to be discarded by reset must not reach the register file.
    assign ld_avail = (fifo_count != '0) && !rst;
    assign ld_ready = !full;
    assign push     = ld_valid && ld_ready && (ld_rd != '0);
    assign pop      = (gnt == GNT_LD);

    wb_ret_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (full),
        .ent_rd    (ent_rd),
        .ent_valid (ent_valid)
    );

    always_comb begin
        gnt = GNT_NONE;
        if (!ld_avail) begin
            if (alu_req) gnt = GNT_ALU;
        end else if (alu_req && (stall_cnt == SW'(MAX_STALL))) begin
            gnt = GNT_ALU;
        end else begin
            gnt = GNT_LD;
        end

        rf_we     = (gnt != GNT_NONE);
        rf_waddr  = '0;
        rf_wdata  = '0;
        alu_stall = alu_req && (gnt != GNT_ALU);
        unique case (gnt)
            GNT_ALU: begin
                rf_waddr = alu_rd;
                rf_wdata = alu_data;
            end
            GNT_LD: begin
                rf_waddr = head_rd;
                rf_wdata = head_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!alu_req || (gnt == GNT_ALU)) begin
            stall_cnt <= '0;
        end else if (stall_cnt != SW'(MAX_STALL)) begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

    always_comb begin
        q_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == q_rs)) q_pending = 1'b1;
        end
        if (q_rs == '0) q_pending = 1'b0;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: accepted loads are queued as expected
// writes and retired when the port should grant them.
module tb_wb_port_arbiter;
    import cpu_pkg::*;

    localparam int unsigned XW        = 32;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned MAX_STALL = 4;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XW-1:0]   alu_data;
    logic            alu_stall;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XW-1:0]   ld_data;
    logic            ld_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XW-1:0]   rf_wdata;
    logic [4:0]      q_rs;
    logic            q_pending;
    logic [CW-1:0]   fifo_count;

    wb_port_arbiter #(
        .XLEN      (XW),
        .DEPTH     (DEPTH),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .q_rs       (q_rs),
        .q_pending  (q_pending),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    rd;
        logic [XW-1:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int unsigned m_stall = 0;
    int          n_cmp   = 0;
    int          n_err   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs against the
    // expected state, then advance the scoreboard to what the next edge does.
    task automatic step(input logic r, input logic av, input logic [4:0] ard,
                        input logic [XW-1:0] ad, input logic lv, input logic [4:0] lrd,
                        input logic [XW-1:0] ldd, input logic [4:0] qrs,
                        output logic alu_gnt, output logic ld_acc, output logic st);
        logic          areq;
        logic          lavail;
        logic          g_alu;
        logic          g_ld;
        logic          pend;
        int unsigned   cnt;
        wr_t           hd;
        @(negedge clk);
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ldd; q_rs = qrs;
        #1;
        areq   = av && (ard != 5'd0);
        cnt    = sb_q.size();
        lavail = (cnt != 0) && !r;
        g_alu  = 1'b0;
        g_ld   = 1'b0;
        if (!lavail) g_alu = areq;
        else if (areq && m_stall >= MAX_STALL) g_alu = 1'b1;
        else g_ld = 1'b1;
        pend = 1'b0;
        if (qrs != 5'd0) foreach (sb_q[i]) if (sb_q[i].rd == qrs) pend = 1'b1;
        hd = '0;
        if (g_ld) hd = sb_q[0];

        check_eq("rf_we",      64'(rf_we),      64'(g_alu || g_ld));
        check_eq("rf_waddr",   64'(rf_waddr),   g_alu ? 64'(ard) : (g_ld ? 64'(hd.rd) : 64'd0));
        check_eq("rf_wdata",   64'(rf_wdata),   g_alu ? 64'(ad)  : (g_ld ? 64'(hd.data) : 64'd0));
        check_eq("alu_stall",  64'(alu_stall),  64'(areq && !g_alu));
        check_eq("ld_ready",   64'(ld_ready),   64'(cnt < DEPTH));
        check_eq("fifo_count", 64'(fifo_count), 64'(cnt));
        check_eq("q_pending",  64'(q_pending),  64'(pend));
        st = alu_stall;

        ld_acc = lv && (cnt < DEPTH);
        if (r) begin
            sb_q.delete();
            m_stall = 0;
        end else begin
            if (g_ld) void'(sb_q.pop_front());
            if (ld_acc && lrd != 5'd0) sb_q.push_back('{rd: lrd, data: ldd});
            if (!areq || g_alu) m_stall = 0;
            else if (m_stall < MAX_STALL) m_stall++;
        end
        alu_gnt = g_alu;
        @(posedge clk);
    endtask

    initial begin
        logic g, a, st;
        int   n_st;
        int   run;
        int   d;
        logic [4:0] qr;
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; q_rs = '0;

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, g, a, st);
        step(1, 0, 0, 0, 0, 0, 0, 0, g, a, st);

        // ALU write with empty FIFO goes out the same cycle
        step(0, 1, 5, 32'h11, 0, 0, 0, 0, g, a, st);

        // single load: written next cycle, pending only while queued
        step(0, 0, 0, 0, 1, 7, 32'hAB, 7, g, a, st);
        step(0, 0, 0, 0, 0, 0, 0, 7, g, a, st);
        step(0, 0, 0, 0, 0, 0, 0, 7, g, a, st);

        // two back-to-back loads ahead of a held ALU request
        step(0, 0, 0, 0, 1, 10, 32'hA0, 10, g, a, st);
        step(0, 1, 3, 32'h33, 1, 11, 32'hA1, 11, g, a, st);
        n_st = st ? 1 : 0;
        for (int k = 0; k < 8 && !g; k++) begin
            step(0, 1, 3, 32'h33, 0, 0, 0, 11, g, a, st);
            if (st) n_st++;
        end
        check_eq("alu_held_stall_cycles", 64'(n_st), 64'd2);

        // x0 destinations: no write, no stall, load handshake without enqueue
        step(0, 1, 0, 32'hDEAD, 0, 0, 0, 0, g, a, st);
        step(0, 0, 0, 0, 1, 0, 32'hBEEF, 0, g, a, st);
        check_eq("x0_load_handshake", 64'(a), 64'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g, a, st);

        // continuous load stream against a persistent ALU request
        d = 'h100;
        step(0, 0, 0, 0, 1, 5'(12 + (d % 8)), 32'(d), 0, g, a, st);
        if (a) d++;
        for (int op = 0; op < 3; op++) begin
            g   = 1'b0;
            run = 0;
            for (int k = 0; k < 12 && !g; k++) begin
                step(0, 1, 5'(20 + op), 32'(32'hC0 + op), 1, 5'(12 + (d % 8)), 32'(d), 5'(12 + (d % 8)), g, a, st);
                if (a) d++;
                if (st) run++;
            end
            check_eq("starve_stall_run", 64'(run), 64'(MAX_STALL));
            check_eq("starve_alu_granted", 64'(g), 64'd1);
        end

        // reset with a full FIFO discards both entries without writing them
        check_eq("pre_reset_count", 64'(sb_q.size()), 64'(DEPTH));
        qr = (sb_q.size() != 0) ? sb_q[0].rd : 5'd12;
        step(1, 0, 0, 0, 0, 0, 0, qr, g, a, st);
        step(0, 0, 0, 0, 0, 0, 0, qr, g, a, st);
        step(0, 0, 0, 0, 0, 0, 0, qr, g, a, st);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
